// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single external memory bus between NUM_PORTS requesters
// (instruction cache, data cache, DMA, ...). One transaction is in flight at a
// time. The winner is chosen either by fixed priority (lowest index) or by
// round-robin. A per-transaction timeout turns a stuck memory access into an
// error response.
//
// Every output is registered, so no input reaches an output combinationally.
//
// Parameters:
//   WORD_SIZE  data width of every port and of the external bus
//   NUM_PORTS  number of requesters, 2..8
//   ARB_MODE   0 = fixed priority (lowest index wins), 1 = round-robin
//   TIMEOUT    max BUSY cycles before an error response, 0 disables it
//
// Ports:
//   clk            clock, every state update happens on the rising edge
//   rst            asynchronous reset, active low
//   req            per-port request level, held by the requester until ack
//   req_we         per-port direction, 1 = write, 0 = read
//   req_addr       per-port 32-bit address, port i at [32*i +: 32]
//   req_wdata      per-port write data, port i at [WORD_SIZE*i +: WORD_SIZE]
//   req_ack        one-cycle one-hot completion pulse
//   req_err        high together with req_ack when the access timed out
//   rsp_rdata      read data, valid while req_ack is high
//   grant_id       index of the port being served
//   busy           high while a transaction is in progress or completing
//   mem_addr       external address
//   en_ext_mem_re  external read enable
//   en_ext_mem_wr  external write enable
//   data_in        write data driven to external memory
//   data_out       read data returned by external memory
//   mem_ready      external completion, only looked at while BUSY
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 64,
  localparam int ID_W     = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           req_we,
  input  logic [32*NUM_PORTS-1:0]        req_addr,
  input  logic [WORD_SIZE*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]           req_ack,
  output logic                           req_err,
  output logic [WORD_SIZE-1:0]           rsp_rdata,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy,
  output logic [31:0]                    mem_addr,
  output logic                           en_ext_mem_re,
  output logic                           en_ext_mem_wr,
  output logic [WORD_SIZE-1:0]           data_in,
  input  logic [WORD_SIZE-1:0]           data_out,
  input  logic                           mem_ready
);

  // The counter only has to reach TIMEOUT-1; with the timeout disabled it
  // simply wraps and is never compared.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic             found;
  int               idx;

  // Winner selection. Both searches walk from the lowest-priority candidate
  // to the highest so that the last hit (highest priority) is kept.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req[ID_W'(i)]) begin
          found  = 1'b1;
          winner = ID_W'(i);
        end
      end
    end else begin
      // Round-robin: the port right after the last winner is searched first.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_PORTS;
        if (req[ID_W'(idx)]) begin
          found  = 1'b1;
          winner = ID_W'(idx);
        end
      end
    end
  end

  // Transaction FSM. The winner's payload is copied straight into the bus
  // output registers at grant, so later payload changes cannot leak through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= ID_W'(NUM_PORTS - 1);
      req_ack       <= '0;
      req_err       <= 1'b0;
      rsp_rdata     <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      mem_addr      <= '0;
      en_ext_mem_re <= 1'b0;
      en_ext_mem_wr <= 1'b0;
      data_in       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ack <= '0;
          if (found) begin
            grant_id      <= winner;
            mem_addr      <= req_addr[32*winner +: 32];
            en_ext_mem_re <= ~req_we[winner];
            en_ext_mem_wr <= req_we[winner];
            data_in       <= req_we[winner] ? req_wdata[WORD_SIZE*winner +: WORD_SIZE]
                                            : '0;
            busy          <= 1'b1;
            cnt           <= '0;
            if (ARB_MODE != 0) begin
              rr_ptr <= winner;
            end
            state <= BUSY;
          end
        end

        BUSY: begin
          cnt <= cnt + 1'b1;
          // mem_ready is tested first so it beats a coincident timeout.
          if (mem_ready || (TIMEOUT != 0 && cnt == CNT_LAST)) begin
            rsp_rdata     <= (mem_ready && !en_ext_mem_wr) ? data_out : '0;
            req_err       <= ~mem_ready;
            req_ack       <= ONE_HOT0 << grant_id;
            mem_addr      <= '0;
            en_ext_mem_re <= 1'b0;
            en_ext_mem_wr <= 1'b0;
            data_in       <= '0;
            state         <= DONE;
          end
        end

        DONE: begin
          req_ack   <= '0;
          req_err   <= 1'b0;
          rsp_rdata <= '0;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances share clock and reset:
//   dut_a: 2 ports, fixed priority, TIMEOUT = 8
//   dut_b: 4 ports, round-robin, timeout disabled
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [1:0]  a_req, a_req_we, a_req_ack;
  logic [63:0] a_req_addr, a_req_wdata;
  logic        a_req_err, a_grant_id, a_busy, a_re, a_wr, a_mem_ready;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_data_in, a_data_out;

  logic [3:0]   b_req, b_req_we, b_req_ack;
  logic [127:0] b_req_addr, b_req_wdata;
  logic         b_req_err, b_busy, b_re, b_wr, b_mem_ready;
  logic [1:0]   b_grant_id;
  logic [31:0]  b_rsp_rdata, b_mem_addr, b_data_in, b_data_out;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.WORD_SIZE(32), .NUM_PORTS(2), .ARB_MODE(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .req_we(a_req_we), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_ack(a_req_ack), .req_err(a_req_err),
    .rsp_rdata(a_rsp_rdata), .grant_id(a_grant_id), .busy(a_busy),
    .mem_addr(a_mem_addr), .en_ext_mem_re(a_re), .en_ext_mem_wr(a_wr),
    .data_in(a_data_in), .data_out(a_data_out), .mem_ready(a_mem_ready)
  );

  mem_port_arbiter #(.WORD_SIZE(32), .NUM_PORTS(4), .ARB_MODE(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .req_we(b_req_we), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ack(b_req_ack), .req_err(b_req_err),
    .rsp_rdata(b_rsp_rdata), .grant_id(b_grant_id), .busy(b_busy),
    .mem_addr(b_mem_addr), .en_ext_mem_re(b_re), .en_ext_mem_wr(b_wr),
    .data_in(b_data_in), .data_out(b_data_out), .mem_ready(b_mem_ready)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en_cycles;
    logic [1:0] exp_id;

    rst = 1'b0;
    a_req = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0;
    a_data_out = '0; a_mem_ready = 1'b0;
    b_req = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0;
    b_data_out = '0; b_mem_ready = 1'b0;

    // Reset values
    tick(); tick();
    check_output("rst_a_busy", 32'(a_busy), 32'd0);
    check_output("rst_a_ack", 32'(a_req_ack), 32'd0);
    check_output("rst_a_en", 32'({a_re, a_wr}), 32'd0);
    check_output("rst_b_busy", 32'(b_busy), 32'd0);
    check_output("rst_b_grant", 32'(b_grant_id), 32'd0);
    rst = 1'b1;
    tick();
    check_output("idle_a_en", 32'({a_re, a_wr}), 32'd0);
    check_output("idle_a_addr", a_mem_addr, 32'd0);

    // Single read, port 0, two BUSY cycles before mem_ready
    a_req = 2'b01; a_req_we = 2'b00; a_req_addr[31:0] = 32'h100;
    tick();
    check_output("t1_re_c1", 32'(a_re), 32'd1);
    check_output("t1_wr_c1", 32'(a_wr), 32'd0);
    check_output("t1_addr", a_mem_addr, 32'h100);
    check_output("t1_data_in", a_data_in, 32'd0);
    check_output("t1_busy", 32'(a_busy), 32'd1);
    check_output("t1_ack_c1", 32'(a_req_ack), 32'd0);
    tick();
    check_output("t1_re_c2", 32'(a_re), 32'd1);
    a_mem_ready = 1'b1; a_data_out = 32'hDEADBEEF;
    tick();
    check_output("t1_ack", 32'(a_req_ack), 32'h1);
    check_output("t1_rdata", a_rsp_rdata, 32'hDEADBEEF);
    check_output("t1_err", 32'(a_req_err), 32'd0);
    check_output("t1_re_done", 32'(a_re), 32'd0);
    check_output("t1_addr_done", a_mem_addr, 32'd0);
    a_req = 2'b00; a_mem_ready = 1'b0;
    tick();
    check_output("t1_ack_off", 32'(a_req_ack), 32'd0);
    check_output("t1_busy_off", 32'(a_busy), 32'd0);

    // Write, port 1, zero wait
    a_req = 2'b10; a_req_we = 2'b10; a_req_addr[63:32] = 32'h40;
    a_req_wdata[63:32] = 32'h12345678; a_mem_ready = 1'b1;
    tick();
    check_output("t2_wr", 32'(a_wr), 32'd1);
    check_output("t2_re", 32'(a_re), 32'd0);
    check_output("t2_data_in", a_data_in, 32'h12345678);
    check_output("t2_addr", a_mem_addr, 32'h40);
    check_output("t2_grant", 32'(a_grant_id), 32'd1);
    a_req_wdata[63:32] = 32'hFFFF0000;
    tick();
    check_output("t2_ack", 32'(a_req_ack), 32'h2);
    check_output("t2_wr_off", 32'(a_wr), 32'd0);
    check_output("t2_rdata", a_rsp_rdata, 32'd0);
    a_req = 2'b00; a_req_we = 2'b00; a_mem_ready = 1'b0;
    tick();
    check_output("t2_ack_off", 32'(a_req_ack), 32'd0);

    // Fixed priority: port 0 wins while it keeps requesting
    a_req = 2'b11; a_mem_ready = 1'b1; a_data_out = 32'h0000AAAA;
    for (int n = 0; n < 2; n++) begin
      tick();
      check_output("t4_grant0", 32'(a_grant_id), 32'd0);
      tick();
      check_output("t4_ack0", 32'(a_req_ack), 32'h1);
      tick();
      check_output("t4_idle", 32'(a_busy), 32'd0);
    end
    a_req = 2'b10;
    tick();
    check_output("t4_grant1", 32'(a_grant_id), 32'd1);
    tick();
    check_output("t4_ack1", 32'(a_req_ack), 32'h2);
    a_req = 2'b00; a_mem_ready = 1'b0;
    tick();

    // Timeout after 8 BUSY cycles, then a late mem_ready is ignored
    a_req = 2'b01; a_req_we = 2'b00; a_data_out = 32'hFFFFFFFF;
    en_cycles = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (a_re) en_cycles++;
    end
    check_output("t5_en_cycles", 32'(en_cycles), 32'd8);
    check_output("t5_ack_early", 32'(a_req_ack), 32'd0);
    tick();
    check_output("t5_ack", 32'(a_req_ack), 32'h1);
    check_output("t5_err", 32'(a_req_err), 32'd1);
    check_output("t5_rdata", a_rsp_rdata, 32'd0);
    check_output("t5_re_off", 32'(a_re), 32'd0);
    a_req = 2'b00; a_mem_ready = 1'b1;
    tick();
    check_output("t5_late_ack", 32'(a_req_ack), 32'd0);
    check_output("t5_late_err", 32'(a_req_err), 32'd0);
    tick();
    check_output("t5_idle_busy", 32'(a_busy), 32'd0);
    check_output("t5_idle_en", 32'({a_re, a_wr}), 32'd0);
    a_mem_ready = 1'b0;

    // Round-robin over four ports, all requesting, zero wait
    b_req = 4'b1111; b_req_we = 4'b0000; b_mem_ready = 1'b1; b_data_out = 32'hC0DE0001;
    b_req_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0500};
    for (int n = 0; n < 5; n++) begin
      exp_id = 2'(n % 4);
      tick();
      check_output("t3_grant", 32'(b_grant_id), 32'(exp_id));
      check_output("t3_ack_busy", 32'(b_req_ack), 32'd0);
      tick();
      check_output("t3_ack", 32'(b_req_ack), 32'(4'b0001 << exp_id));
      check_output("t3_rdata", b_rsp_rdata, 32'hC0DE0001);
      tick();
      check_output("t3_ack_idle", 32'(b_req_ack), 32'd0);
    end
    b_req = 4'b0000; b_mem_ready = 1'b0;
    tick();

    // Reset in the middle of BUSY aborts the op and restores the pointer
    b_req = 4'b0100;
    tick();
    check_output("t6_grant2", 32'(b_grant_id), 32'd2);
    check_output("t6_re", 32'(b_re), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("t6_rst_re", 32'(b_re), 32'd0);
    check_output("t6_rst_busy", 32'(b_busy), 32'd0);
    check_output("t6_rst_addr", b_mem_addr, 32'd0);
    check_output("t6_rst_grant", 32'(b_grant_id), 32'd0);
    tick();
    check_output("t6_rst_ack", 32'(b_req_ack), 32'd0);
    rst = 1'b1; b_req = 4'b1111; b_mem_ready = 1'b1;
    tick();
    check_output("t6_first_grant", 32'(b_grant_id), 32'd0);
    check_output("t6_first_addr", b_mem_addr, 32'h0500);
    tick();
    check_output("t6_first_ack", 32'(b_req_ack), 32'h1);
    b_req = 4'b0000; b_mem_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
